pipe_decode_rf: RTL and testbench
=================================

PIPE_DECODE_RF -- requirements
Module: pipe_decode_rf

Interface
REQ-001 SHALL parameter DATA_W, 64, register and operand width in bits.
REQ-002 SHALL parameter NREGS, 15, number of architectural registers; indices 0..NREGS-1 are valid.
REQ-003 SHALL parameter RSP_IDX, 4, index of the stack pointer.
REQ-004 SHALL parameter RNONE, 15, "no register" index; must be >= NREGS.
REQ-005 SHALL port clock  in  1  single clock; all state updates on its rising edge.
REQ-006 SHALL port reset  in  1  reset, synchronous and active-high.
REQ-007 SHALL port in_valid  in  1  icode/ra/rb carry a real instruction this cycle.
REQ-008 SHALL port icode, ra, rb  in  4 each  instruction fields from fetch.
REQ-009 SHALL port stall  in  1  hold the decode output register.
REQ-010 SHALL port bubble  in  1  load a nop into the decode output register.
REQ-011 SHALL port we_e, dst_e, val_e  in  1/4/DATA_W  write port E (ALU result).
REQ-012 SHALL port we_m, dst_m, val_m  in  1/4/DATA_W  write port M (memory result).
REQ-013 SHALL port out_valid  out  1  registered vala/valb/srca/srcb are valid.
REQ-014 SHALL port vala, valb  out  DATA_W each  registered operand values.
REQ-015 SHALL port srca, srcb  out  4 each  registered source indices, RNONE when unused.

Function
REQ-016 SHALL hold NREGS x DATA_W storage registers, written on the rising clock edge.
REQ-017 SHALL derive sources combinationally from icode (any other icode, including 0/1/3/7, gives RNONE/RNONE):
  - 2 (cmovxx): srcA=ra, srcB=RNONE
  - 4 (rmmovq), 6 (opq): srcA=ra, srcB=rb
  - 5 (mrmovq): srcA=RNONE, srcB=rb
  - 8 (call): srcA=RNONE, srcB=RSP_IDX
  - 9 (ret), 11 (popq): srcA=RSP_IDX, srcB=RSP_IDX
  - 10 (pushq): srcA=ra, srcB=RSP_IDX
REQ-018 SHALL return 0 for a read of RNONE or of any index >= NREGS.
REQ-019 SHALL perform a write when we_x=1 and dst_x<NREGS; otherwise that port is ignored.
REQ-020 SHALL let port M win when both ports write the same index in the same cycle (popq %rsp semantics).
REQ-021 SHALL bypass write to read: a read of an index written in the same cycle returns the value being written, with M taking priority over E.
REQ-022 SHALL apply latency 1: operands read in cycle N appear on vala/valb/srca/srcb/out_valid after edge N+1.
REQ-023 SHALL, when stall=1, hold all output registers unchanged; register-file writes still occur.
REQ-024 SHALL, when bubble=1 and stall=0, load out_valid=0, vala=valb=0, srca=srcb=RNONE.
REQ-025 SHALL treat stall=1 with bubble=1 as stall (stall has priority).
REQ-026 SHALL, when stall=0 and bubble=0, load out_valid=in_valid and the read results; with in_valid=0 it loads the bubble values.
REQ-027 SHALL never assign undefined values: every icode assigns both operands (0 when unused), so no latch is inferred.

Reset
REQ-028 SHALL, on reset=1 at a rising edge, clear all NREGS registers to 0, set out_valid=0, vala=valb=0, srca=srcb=RNONE.
REQ-029 SHALL give reset priority over stall, bubble and both write ports.
REQ-030 SHALL abandon an instruction in flight when reset is asserted mid-stream; the first valid output after reset deasserts comes from an instruction presented after deassertion.

Structure
REQ-031 SHALL take the icode constants (IHALT..IPOPQ), RNONE, RSP_IDX and the default DATA_W from the shared Y86 package used by fetch/execute/memory.
REQ-032 SHALL use exactly one sub-module, y86_regfile (storage, two write ports, two bypassed read ports); the source decode and output register stay in pipe_decode_rf.

Verification
REQ-033 SHALL cover: reset, then write r3=0x11 via E, next cycle opq ra=3 rb=3 -> vala=valb=0x11 with out_valid=1 one cycle later.
REQ-034 SHALL cover: same-cycle we_e dst=4 val=0x100 and we_m dst=4 val=0x200 -> rsp reads 0x200.
REQ-035 SHALL cover: pushq ra=2 issued in the same cycle r2 is written with 0x55 -> vala=0x55 (bypass) and valb=current rsp.
REQ-036 SHALL cover: stall held 3 cycles with a changing icode -> outputs frozen; a write during the stall is visible after release.
REQ-037 SHALL cover: bubble=1 -> out_valid=0, srca=srcb=15; stall+bubble together -> outputs held.
REQ-038 SHALL cover: write to dst=15 or read with icode=3 -> no state change and operands=0; reset mid-stream -> all registers 0.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86 definitions: instruction codes, register-index constants and the
// default datapath width used by the fetch, decode, execute and memory stages.
package y86_pkg;

    // Default datapath and register-file geometry
    localparam int unsigned Y86_DATA_W = 64;
    localparam int unsigned Y86_NREGS  = 15;
    localparam int unsigned Y86_RSP    = 4;
    localparam int unsigned Y86_RNONE  = 15;
    localparam int unsigned REG_IDX_W  = 4;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    // Instruction codes as they arrive from fetch
    typedef enum logic [3:0] {
        IHALT   = 4'h0,
        INOP    = 4'h1,
        IRRMOVQ = 4'h2,
        IIRMOVQ = 4'h3,
        IRMMOVQ = 4'h4,
        IMRMOVQ = 4'h5,
        IOPQ    = 4'h6,
        IJXX    = 4'h7,
        ICALL   = 4'h8,
        IRET    = 4'h9,
        IPUSHQ  = 4'hA,
        IPOPQ   = 4'hB
    } icode_e;

    // Pair of source register indices produced by decode
    typedef struct packed {
        reg_idx_t srcA;
        reg_idx_t srcB;
    } src_pair_t;

    // Builds a source pair; keeps the decode case statement compact
    function automatic src_pair_t srcPair(input reg_idx_t a, input reg_idx_t b);
        src_pair_t p;
        p.srcA = a;
        p.srcB = b;
        return p;
    endfunction

endpackage

// File: rtl/y86_regfile.sv
// Y86 register file: NREGS storage registers, two write ports (E and M) and
// two read ports that see same-cycle writes through a bypass.
module y86_regfile
    import y86_pkg::*;
#(
    parameter int unsigned DATA_W = Y86_DATA_W,
    parameter int unsigned NREGS  = Y86_NREGS
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              weE_i,
    input  reg_idx_t          dstE_i,
    input  logic [DATA_W-1:0] valE_i,
    input  logic              weM_i,
    input  reg_idx_t          dstM_i,
    input  logic [DATA_W-1:0] valM_i,
    input  reg_idx_t          rdAddrA_i,
    input  reg_idx_t          rdAddrB_i,
    output logic [DATA_W-1:0] rdDataA_o,
    output logic [DATA_W-1:0] rdDataB_o
);

    logic [DATA_W-1:0] regs_q [NREGS];

    logic wrE;
    logic wrM;
    logic rdAValid;
    logic rdBValid;

    // A port only writes when enabled and aimed at a real register; indices
    // at or above NREGS (including the "no register" code) are dropped.
    assign wrE      = weE_i && (32'(dstE_i) < NREGS);
    assign wrM      = weM_i && (32'(dstM_i) < NREGS);
    assign rdAValid = 32'(rdAddrA_i) < NREGS;
    assign rdBValid = 32'(rdAddrB_i) < NREGS;

    // Storage update; M is assigned last so it wins a same-index collision,
    // which gives popq %rsp its architectural result.
    always_ff @(posedge clock) begin
        if (reset) begin
            regs_q <= '{default: '0};
        end else begin
            if (wrE) begin
                regs_q[dstE_i] <= valE_i;
            end
            if (wrM) begin
                regs_q[dstM_i] <= valM_i;
            end
        end
    end

    // Bypassed reads: out-of-range reads return 0, otherwise M then E then storage.
    always_comb begin
        rdDataA_o = '0;
        rdDataB_o = '0;
        if (rdAValid) begin
            if (wrM && (dstM_i == rdAddrA_i)) begin
                rdDataA_o = valM_i;
            end else if (wrE && (dstE_i == rdAddrA_i)) begin
                rdDataA_o = valE_i;
            end else begin
                rdDataA_o = regs_q[rdAddrA_i];
            end
        end
        if (rdBValid) begin
            if (wrM && (dstM_i == rdAddrB_i)) begin
                rdDataB_o = valM_i;
            end else if (wrE && (dstE_i == rdAddrB_i)) begin
                rdDataB_o = valE_i;
            end else begin
                rdDataB_o = regs_q[rdAddrB_i];
            end
        end
    end

endmodule

// File: rtl/pipe_decode_rf.sv
// Decode stage of the Y86 pipeline: picks source registers from icode, reads
// them from the register file (with write bypass) and registers the operands
// for execute, honouring stall and bubble control from the hazard unit.
module pipe_decode_rf
    import y86_pkg::*;
#(
    parameter int unsigned DATA_W  = Y86_DATA_W,
    parameter int unsigned NREGS   = Y86_NREGS,
    parameter int unsigned RSP_IDX = Y86_RSP,
    parameter int unsigned RNONE   = Y86_RNONE
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [3:0]        icode,
    input  logic [3:0]        ra,
    input  logic [3:0]        rb,
    input  logic              stall,
    input  logic              bubble,
    input  logic              we_e,
    input  logic [3:0]        dst_e,
    input  logic [DATA_W-1:0] val_e,
    input  logic              we_m,
    input  logic [3:0]        dst_m,
    input  logic [DATA_W-1:0] val_m,
    output logic              out_valid,
    output logic [DATA_W-1:0] vala,
    output logic [DATA_W-1:0] valb,
    output logic [3:0]        srca,
    output logic [3:0]        srcb
);

    localparam reg_idx_t RNONE_IDX = reg_idx_t'(RNONE);
    localparam reg_idx_t RSP_REG   = reg_idx_t'(RSP_IDX);

    src_pair_t         srcs;
    logic [DATA_W-1:0] rdDataA;
    logic [DATA_W-1:0] rdDataB;

    logic              outValid_q, outValid_d;
    logic [DATA_W-1:0] valA_q, valA_d;
    logic [DATA_W-1:0] valB_q, valB_d;
    reg_idx_t          srcA_q, srcA_d;
    reg_idx_t          srcB_q, srcB_d;

    // Source selection per instruction; anything not listed reads nothing.
    always_comb begin
        srcs = srcPair(RNONE_IDX, RNONE_IDX);
        case (icode_e'(icode))
            IRRMOVQ:        srcs = srcPair(ra, RNONE_IDX);
            IRMMOVQ, IOPQ:  srcs = srcPair(ra, rb);
            IMRMOVQ:        srcs = srcPair(RNONE_IDX, rb);
            ICALL:          srcs = srcPair(RNONE_IDX, RSP_REG);
            IRET, IPOPQ:    srcs = srcPair(RSP_REG, RSP_REG);
            IPUSHQ:         srcs = srcPair(ra, RSP_REG);
            default:        srcs = srcPair(RNONE_IDX, RNONE_IDX);
        endcase
    end

    y86_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clock     (clock),
        .reset     (reset),
        .weE_i     (we_e),
        .dstE_i    (dst_e),
        .valE_i    (val_e),
        .weM_i     (we_m),
        .dstM_i    (dst_m),
        .valM_i    (val_m),
        .rdAddrA_i (srcs.srcA),
        .rdAddrB_i (srcs.srcB),
        .rdDataA_o (rdDataA),
        .rdDataB_o (rdDataB)
    );

    // Next operand register: hold on stall, nop on bubble or empty slot, else load.
    always_comb begin
        outValid_d = outValid_q;
        valA_d     = valA_q;
        valB_d     = valB_q;
        srcA_d     = srcA_q;
        srcB_d     = srcB_q;
        if (!stall) begin
            if (bubble || !in_valid) begin
                outValid_d = 1'b0;
                valA_d     = '0;
                valB_d     = '0;
                srcA_d     = RNONE_IDX;
                srcB_d     = RNONE_IDX;
            end else begin
                outValid_d = 1'b1;
                valA_d     = rdDataA;
                valB_d     = rdDataB;
                srcA_d     = srcs.srcA;
                srcB_d     = srcs.srcB;
            end
        end
    end

    // Operand register; reset wins over every other control and drops work in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            outValid_q <= 1'b0;
            valA_q     <= '0;
            valB_q     <= '0;
            srcA_q     <= RNONE_IDX;
            srcB_q     <= RNONE_IDX;
        end else begin
            outValid_q <= outValid_d;
            valA_q     <= valA_d;
            valB_q     <= valB_d;
            srcA_q     <= srcA_d;
            srcB_q     <= srcB_d;
        end
    end

    assign out_valid = outValid_q;
    assign vala      = valA_q;
    assign valb      = valB_q;
    assign srca      = srcA_q;
    assign srcb      = srcB_q;

endmodule

// File: tb/tb_pipe_decode_rf.sv
// Directed bench for pipe_decode_rf: a table of single-cycle vectors followed
// by hand-written stall and mid-stream reset sequences.
module tb_pipe_decode_rf;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [3:0]  icode, ra, rb;
    logic        stall, bubble;
    logic        we_e, we_m;
    logic [3:0]  dst_e, dst_m;
    logic [63:0] val_e, val_m;
    logic        out_valid;
    logic [63:0] vala, valb;
    logic [3:0]  srca, srcb;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic        inV;
        logic [3:0]  ic, rA, rB;
        logic        weE;
        logic [3:0]  dE;
        logic [63:0] vE;
        logic        weM;
        logic [3:0]  dM;
        logic [63:0] vM;
        logic        bub;
        logic        expV;
        logic [63:0] expA, expB;
        logic [3:0]  expSA, expSB;
    } vec_t;

    vec_t vecs[$];

    pipe_decode_rf dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .icode     (icode),
        .ra        (ra),
        .rb        (rb),
        .stall     (stall),
        .bubble    (bubble),
        .we_e      (we_e),
        .dst_e     (dst_e),
        .val_e     (val_e),
        .we_m      (we_m),
        .dst_m     (dst_m),
        .val_m     (val_m),
        .out_valid (out_valid),
        .vala      (vala),
        .valb      (valb),
        .srca      (srca),
        .srcb      (srcb)
    );

    // Free-running clock, 10 time units per period
    always #5 clock = ~clock;

    function automatic vec_t mkVec(
        input string name, input logic inV, input logic [3:0] ic, input logic [3:0] rA,
        input logic [3:0] rB, input logic weE, input logic [3:0] dE, input logic [63:0] vE,
        input logic weM, input logic [3:0] dM, input logic [63:0] vM, input logic bub,
        input logic expV, input logic [63:0] expA, input logic [63:0] expB,
        input logic [3:0] expSA, input logic [3:0] expSB);
        vec_t v;
        v.name = name; v.inV = inV; v.ic = ic; v.rA = rA; v.rB = rB;
        v.weE = weE; v.dE = dE; v.vE = vE; v.weM = weM; v.dM = dM; v.vM = vM;
        v.bub = bub; v.expV = expV; v.expA = expA; v.expB = expB;
        v.expSA = expSA; v.expSB = expSB;
        return v;
    endfunction

    task automatic idleInputs();
        in_valid = 1'b0; icode = 4'h1; ra = 4'hF; rb = 4'hF;
        stall = 1'b0; bubble = 1'b0;
        we_e = 1'b0; dst_e = 4'hF; val_e = '0;
        we_m = 1'b0; dst_m = 4'hF; val_m = '0;
    endtask

    task automatic applyStimulus(input vec_t v);
        in_valid = v.inV; icode = v.ic; ra = v.rA; rb = v.rB;
        stall = 1'b0; bubble = v.bub;
        we_e = v.weE; dst_e = v.dE; val_e = v.vE;
        we_m = v.weM; dst_m = v.dM; val_m = v.vM;
    endtask

    task automatic stepCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic checkField(input string name, input string field,
                              input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s.%s actual=%h expected=%h", name, field, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic expV, input logic [63:0] expA,
                               input logic [63:0] expB, input logic [3:0] expSA,
                               input logic [3:0] expSB);
        checkField(name, "out_valid", {63'd0, out_valid}, {63'd0, expV});
        checkField(name, "vala", vala, expA);
        checkField(name, "valb", valb, expB);
        checkField(name, "srca", {60'd0, srca}, {60'd0, expSA});
        checkField(name, "srcb", {60'd0, srcb}, {60'd0, expSB});
    endtask

    initial begin
        // name inV ic ra rb | weE dE vE | weM dM vM | bub | expV expA expB sA sB
        vecs.push_back(mkVec("wrR3Nop",      1, 4'h1, 4'hF, 4'hF, 1, 4'h3, 64'h11,   0, 4'hF, 64'h0,   0, 1, 64'h0,    64'h0,    4'hF, 4'hF));
        vecs.push_back(mkVec("opqR3R3",      1, 4'h6, 4'h3, 4'h3, 0, 4'hF, 64'h0,    0, 4'hF, 64'h0,   0, 1, 64'h11,   64'h11,   4'h3, 4'h3));
        vecs.push_back(mkVec("dualWrRspRet", 1, 4'h9, 4'hF, 4'hF, 1, 4'h4, 64'h100,  1, 4'h4, 64'h200, 0, 1, 64'h200,  64'h200,  4'h4, 4'h4));
        vecs.push_back(mkVec("mrmovq",       1, 4'h5, 4'h0, 4'h4, 0, 4'hF, 64'h0,    0, 4'hF, 64'h0,   0, 1, 64'h0,    64'h200,  4'hF, 4'h4));
        vecs.push_back(mkVec("pushqBypass",  1, 4'hA, 4'h2, 4'hF, 0, 4'hF, 64'h0,    1, 4'h2, 64'h55,  0, 1, 64'h55,   64'h200,  4'h2, 4'h4));
        vecs.push_back(mkVec("call",         1, 4'h8, 4'h2, 4'h3, 0, 4'hF, 64'h0,    0, 4'hF, 64'h0,   0, 1, 64'h0,    64'h200,  4'hF, 4'h4));
        vecs.push_back(mkVec("cmov",         1, 4'h2, 4'h2, 4'h3, 0, 4'hF, 64'h0,    0, 4'hF, 64'h0,   0, 1, 64'h55,   64'h0,    4'h2, 4'hF));
        vecs.push_back(mkVec("rmmovqBypE",   1, 4'h4, 4'h3, 4'h2, 1, 4'h3, 64'hAAAA, 1, 4'h7, 64'h77,  0, 1, 64'hAAAA, 64'h55,   4'h3, 4'h2));
        vecs.push_back(mkVec("irmovqNone",   1, 4'h3, 4'h3, 4'h7, 0, 4'hF, 64'h0,    0, 4'hF, 64'h0,   0, 1, 64'h0,    64'h0,    4'hF, 4'hF));
        vecs.push_back(mkVec("wrDst15Popq",  1, 4'hB, 4'hF, 4'hF, 1, 4'hF, 64'hDEAD, 1, 4'hF, 64'hBEEF,0, 1, 64'h200,  64'h200,  4'h4, 4'h4));
        vecs.push_back(mkVec("bubble",       1, 4'h6, 4'h3, 4'h7, 0, 4'hF, 64'h0,    0, 4'hF, 64'h0,   1, 0, 64'h0,    64'h0,    4'hF, 4'hF));
        vecs.push_back(mkVec("inValidLow",   0, 4'h6, 4'h3, 4'h7, 0, 4'hF, 64'h0,    0, 4'hF, 64'h0,   0, 0, 64'h0,    64'h0,    4'hF, 4'hF));
        vecs.push_back(mkVec("opqR7R3",      1, 4'h6, 4'h7, 4'h3, 0, 4'hF, 64'h0,    0, 4'hF, 64'h0,   0, 1, 64'h77,   64'hAAAA, 4'h7, 4'h3));
        vecs.push_back(mkVec("popqBypassE",  1, 4'hB, 4'h0, 4'h0, 1, 4'h4, 64'h300,  0, 4'hF, 64'h0,   0, 1, 64'h300,  64'h300,  4'h4, 4'h4));
        vecs.push_back(mkVec("jxxNone",      1, 4'h7, 4'h3, 4'h3, 0, 4'hF, 64'h0,    0, 4'hF, 64'h0,   0, 1, 64'h0,    64'h0,    4'hF, 4'hF));
        vecs.push_back(mkVec("icode12None",  1, 4'hC, 4'h3, 4'h3, 0, 4'hF, 64'h0,    0, 4'hF, 64'h0,   0, 1, 64'h0,    64'h0,    4'hF, 4'hF));
        vecs.push_back(mkVec("haltNone",     1, 4'h0, 4'h3, 4'h3, 0, 4'hF, 64'h0,    0, 4'hF, 64'h0,   0, 1, 64'h0,    64'h0,    4'hF, 4'hF));
        vecs.push_back(mkVec("wrR14Bypass",  1, 4'h6, 4'hE, 4'h0, 1, 4'hE, 64'hE0,   0, 4'hF, 64'h0,   0, 1, 64'hE0,   64'h0,    4'hE, 4'h0));
        vecs.push_back(mkVec("allOnesR0",    1, 4'h6, 4'h0, 4'hE, 0, 4'hF, 64'h0,    1, 4'h0, '1,      0, 1, '1,       64'hE0,   4'h0, 4'hE));
        vecs.push_back(mkVec("readRnone",    1, 4'h6, 4'hF, 4'hF, 0, 4'hF, 64'h0,    0, 4'hF, 64'h0,   0, 1, 64'h0,    64'h0,    4'hF, 4'hF));
        vecs.push_back(mkVec("r3r7Intact",   1, 4'h6, 4'h3, 4'h7, 0, 4'hF, 64'h0,    0, 4'hF, 64'h0,   0, 1, 64'hAAAA, 64'h77,   4'h3, 4'h7));

        // Power-on reset
        idleInputs();
        reset = 1'b1;
        stepCycle();
        stepCycle();
        checkOutput("reset", 0, 64'h0, 64'h0, 4'hF, 4'hF);
        reset = 1'b0;

        // Table-driven single-cycle vectors
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            stepCycle();
            checkOutput(vecs[i].name, vecs[i].expV, vecs[i].expA, vecs[i].expB,
                        vecs[i].expSA, vecs[i].expSB);
        end

        // Stall for three cycles with changing icode; write lands during the stall
        idleInputs();
        in_valid = 1'b1; icode = 4'h6; ra = 4'h3; rb = 4'h7;
        stepCycle();
        checkOutput("stallLoad", 1, 64'hAAAA, 64'h77, 4'h3, 4'h7);
        stall = 1'b1; icode = 4'h9;
        stepCycle();
        checkOutput("stall1", 1, 64'hAAAA, 64'h77, 4'h3, 4'h7);
        icode = 4'h0; we_e = 1'b1; dst_e = 4'h3; val_e = 64'h1234;
        stepCycle();
        checkOutput("stall2Write", 1, 64'hAAAA, 64'h77, 4'h3, 4'h7);
        we_e = 1'b0; dst_e = 4'hF; val_e = '0;
        bubble = 1'b1; icode = 4'hA; ra = 4'h2;
        stepCycle();
        checkOutput("stallBubble", 1, 64'hAAAA, 64'h77, 4'h3, 4'h7);
        stall = 1'b0; bubble = 1'b0; icode = 4'h6; ra = 4'h3; rb = 4'h3;
        stepCycle();
        checkOutput("stallRelease", 1, 64'h1234, 64'h1234, 4'h3, 4'h3);

        // Reset mid-stream with stall and writes active: reset must win everything
        idleInputs();
        reset = 1'b1; stall = 1'b1; in_valid = 1'b1; icode = 4'h6; ra = 4'h3; rb = 4'h3;
        we_e = 1'b1; dst_e = 4'h5; val_e = 64'h99;
        we_m = 1'b1; dst_m = 4'h3; val_m = 64'h42;
        stepCycle();
        checkOutput("midReset", 0, 64'h0, 64'h0, 4'hF, 4'hF);
        idleInputs();
        reset = 1'b0;
        stepCycle();
        checkOutput("afterResetIdle", 0, 64'h0, 64'h0, 4'hF, 4'hF);
        in_valid = 1'b1; icode = 4'h6; ra = 4'h3; rb = 4'h5;
        stepCycle();
        checkOutput("clearedR3R5", 1, 64'h0, 64'h0, 4'h3, 4'h5);
        ra = 4'h4; rb = 4'h2;
        stepCycle();
        checkOutput("clearedR4R2", 1, 64'h0, 64'h0, 4'h4, 4'h2);
        ra = 4'h0; rb = 4'hE;
        stepCycle();
        checkOutput("clearedR0R14", 1, 64'h0, 64'h0, 4'h0, 4'hE);
        ra = 4'h7; rb = 4'h0;
        stepCycle();
        checkOutput("clearedR7R0", 1, 64'h0, 64'h0, 4'h7, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
